// File: rtl/tri_pkg.sv
// Shared definitions for the triangle host: grid geometry, FSM state
// encoding, vertex type and the pixel-to-bitmap address mapping.
package tri_pkg;

    localparam int GRID    = 8;
    localparam int COORD_W = $clog2(GRID);
    localparam int FRAME_W = GRID * GRID;
    localparam int CNT_W   = $clog2(FRAME_W) + 1;   // must hold 0..64

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND1,
        ST_SEND2,
        ST_SEND3,
        ST_WAIT_BUSY,
        ST_COLLECT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } vertex_t;

    // Bitmap bit index is {y, x}.
    function automatic logic [2*COORD_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tri_frame_buf.sv
// 8x8 pixel bitmap with duplicate detection and distinct-pixel counter.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear        synchronous clear of bitmap and counter
//   wr_en, addr  mark pixel addr ({y,x}) as set
//   frame        registered bitmap
//   pix_cnt      registered count of distinct set pixels (0..64)
//   dup          combinational: the current write hits an already-set bit
module tri_frame_buf
    import tri_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [2*COORD_W-1:0] addr,
    output logic [FRAME_W-1:0]   frame,
    output logic [CNT_W-1:0]     pix_cnt,
    output logic                 dup
);

    logic [FRAME_W-1:0] frame_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hit;

    assign hit = frame_q[addr];
    assign dup = wr_en & hit;

    // The counter only advances on a 0->1 bit transition, so it can never
    // exceed the number of bitmap bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            frame_q <= '0;
            cnt_q   <= '0;
        end else if (wr_en && !hit) begin
            frame_q[addr] <= 1'b1;
            cnt_q         <= cnt_q + CNT_W'(1);
        end
    end

    assign frame   = frame_q;
    assign pix_cnt = cnt_q;

endmodule

// File: rtl/tri_host.sv
// Triangle host: sends one triangle (a, b, c) to the rasterizer as an
// nt-strobed vertex sequence on xi/yi, then captures the po/xo/yo pixel
// stream into an 8x8 bitmap and reports count, duplicates and completion.
// Optional build macro TRI_HOST_TIMEOUT_EN adds a WAIT_BUSY timeout
// (BUSY_WAIT_MAX cycles) and the sticky timeout output.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start, ax..cy          triangle request and vertex coordinates
//   ready, done            idle indicator, one-cycle completion pulse
//   pix_cnt, frame, dup_err  capture results (held until next start)
//   nt, xi, yi             vertex sequence to the rasterizer
//   busy, po, xo, yo       rasterizer status and pixel stream
//   dbg_state              current FSM state
//   timeout                sticky busy-wait timeout (macro builds only)
// Handshake: a request is accepted on the rising edge where start=1 and
// ready=1; start while ready=0 is dropped, never queued. po is a qualifier
// with no back-pressure: every cycle with po=1 in COLLECT is one pixel.
module tri_host
    import tri_pkg::*;
`ifdef TRI_HOST_TIMEOUT_EN
#(
    parameter int BUSY_WAIT_MAX = 15
)
`endif
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    output logic               ready,
    output logic               done,
    output logic [CNT_W-1:0]   pix_cnt,
    output logic [FRAME_W-1:0] frame,
    output logic               dup_err,
    output logic               nt,
    output logic [COORD_W-1:0] xi,
    output logic [COORD_W-1:0] yi,
    input  logic               busy,
    input  logic               po,
    input  logic [COORD_W-1:0] xo,
    input  logic [COORD_W-1:0] yo,
    output state_e             dbg_state
`ifdef TRI_HOST_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    state_e             state_q, state_d;
    vertex_t            va_q, va_d, vb_q, vb_d, vc_q, vc_d;
    logic               seen_q, seen_d;
    logic               dup_err_q, dup_err_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               nt_q, nt_d;
    logic [COORD_W-1:0] xi_q, xi_d, yi_q, yi_d;
    logic               fb_clear, fb_wr, fb_dup;
`ifdef TRI_HOST_TIMEOUT_EN
    logic               timeout_q, timeout_d;
    logic [3:0]         wcnt_q, wcnt_d;
`endif

    tri_frame_buf u_frame_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (fb_clear),
        .wr_en   (fb_wr),
        .addr    (pix_addr(xo, yo)),
        .frame   (frame),
        .pix_cnt (pix_cnt),
        .dup     (fb_dup)
    );

    always_comb begin
        state_d   = state_q;
        va_d      = va_q;
        vb_d      = vb_q;
        vc_d      = vc_q;
        seen_d    = seen_q;
        dup_err_d = dup_err_q;
        fb_clear  = 1'b0;
        fb_wr     = 1'b0;
`ifdef TRI_HOST_TIMEOUT_EN
        timeout_d = timeout_q;
        wcnt_d    = wcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    va_d      = '{x: ax, y: ay};
                    vb_d      = '{x: bx, y: by};
                    vc_d      = '{x: cx, y: cy};
                    seen_d    = 1'b0;
                    dup_err_d = 1'b0;
                    fb_clear  = 1'b1;
`ifdef TRI_HOST_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = ST_SEND1;
                end
            end
            ST_SEND1: state_d = ST_SEND2;
            ST_SEND2: begin
                // The rasterizer may raise busy as soon as it sees nt.
                if (busy) seen_d = 1'b1;
                state_d = ST_SEND3;
            end
            ST_SEND3: begin
                if (busy) seen_d = 1'b1;
`ifdef TRI_HOST_TIMEOUT_EN
                wcnt_d = '0;
`endif
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (seen_q || busy) begin
                    seen_d  = 1'b1;
                    state_d = ST_COLLECT;
                end
`ifdef TRI_HOST_TIMEOUT_EN
                else if (wcnt_q == 4'(BUSY_WAIT_MAX - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
`endif
            end
            ST_COLLECT: begin
                // po is honoured even on the cycle busy falls.
                fb_wr = po;
                if (fb_dup) dup_err_d = 1'b1;
                if (!busy) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they describe.
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        nt_d    = (state_d == ST_SEND1);
        xi_d    = xi_q;
        yi_d    = yi_q;
        case (state_d)
            ST_SEND1:                begin xi_d = va_d.x; yi_d = va_d.y; end
            ST_SEND2:                begin xi_d = vb_d.x; yi_d = vb_d.y; end
            ST_SEND3, ST_WAIT_BUSY:  begin xi_d = vc_d.x; yi_d = vc_d.y; end
            default:                 ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            va_q      <= '0;
            vb_q      <= '0;
            vc_q      <= '0;
            seen_q    <= 1'b0;
            dup_err_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            nt_q      <= 1'b0;
            xi_q      <= '0;
            yi_q      <= '0;
`ifdef TRI_HOST_TIMEOUT_EN
            timeout_q <= 1'b0;
            wcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            va_q      <= va_d;
            vb_q      <= vb_d;
            vc_q      <= vc_d;
            seen_q    <= seen_d;
            dup_err_q <= dup_err_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            nt_q      <= nt_d;
            xi_q      <= xi_d;
            yi_q      <= yi_d;
`ifdef TRI_HOST_TIMEOUT_EN
            timeout_q <= timeout_d;
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign dup_err   = dup_err_q;
    assign nt        = nt_q;
    assign xi        = xi_q;
    assign yi        = yi_q;
    assign dbg_state = state_q;
`ifdef TRI_HOST_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_tri_host.sv
module tb_tri_host;
  import tri_pkg::*;

  localparam int EXP_W = 64 + 7 + 1;   // {frame, pix_cnt, dup_err}

  logic       clk, reset, start, busy, po;
  logic [2:0] ax, ay, bx, by, cx, cy, xo, yo;
  logic       ready, done, dup_err, nt;
  logic [6:0] pix_cnt;
  logic [63:0] frame;
  logic [2:0] xi, yi;
  state_e     dbg_state;
`ifdef TRI_HOST_TIMEOUT_EN
  logic       timeout;
`endif

  tri_host dut (
    .clk(clk), .reset(reset), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .ready(ready), .done(done), .pix_cnt(pix_cnt), .frame(frame),
    .dup_err(dup_err), .nt(nt), .xi(xi), .yi(yi),
    .busy(busy), .po(po), .xo(xo), .yo(yo),
    .dbg_state(dbg_state)
`ifdef TRI_HOST_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  logic [2:0] px_q[$];
  logic [2:0] py_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: frame is the set of reported pixels, count is the number of
  // distinct pixels, dup is whether any pixel appears twice in the list.
  function automatic logic [EXP_W-1:0] ref_model();
    bit         seen [8][8];
    logic [63:0] frm = '0;
    int         cnt = 0;
    bit         dup = 0;
    foreach (seen[i, j]) seen[i][j] = 0;
    for (int i = 0; i < px_q.size(); i++) begin
      if (seen[py_q[i]][px_q[i]]) dup = 1;
      else begin
        seen[py_q[i]][px_q[i]] = 1;
        cnt++;
      end
      frm[int'(py_q[i]) * 8 + int'(px_q[i])] = 1'b1;
    end
    return {frm, 7'(cnt), dup};
  endfunction

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 required no pending triangle");
      end else begin
        mon_e = exp_q.pop_front();
        check("frame",   frame,   mon_e[71:8]);
        check("pix_cnt", 64'(pix_cnt), 64'(mon_e[7:1]));
        check("dup_err", 64'(dup_err), 64'(mon_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", 64'(ready), 64'd1);
  endtask

  // Pixels inside the triangle by edge-function sign test (either winding).
  task automatic gen_tri(input int a_x, a_y, b_x, b_y, c_x, c_y);
    int e0, e1, e2;
    px_q.delete();
    py_q.delete();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        e0 = (b_x - a_x) * (y - a_y) - (b_y - a_y) * (x - a_x);
        e1 = (c_x - b_x) * (y - b_y) - (c_y - b_y) * (x - b_x);
        e2 = (a_x - c_x) * (y - c_y) - (a_y - c_y) * (x - c_x);
        if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
          px_q.push_back(3'(x));
          py_q.push_back(3'(y));
        end
      end
  endtask

  task automatic send_start(input logic [2:0] a_x, a_y, b_x, b_y, c_x, c_y);
    @(posedge clk); #1;
    start = 1'b1;
    ax = a_x; ay = a_y; bx = b_x; by = b_y; cx = c_x; cy = c_y;
    @(posedge clk); #1;   // accepting edge just passed
    start = 1'b0;
  endtask

  // Plays the rasterizer: checks the vertex sequence, raises busy, streams
  // px_q/py_q, then drops busy. early: busy pulses only during SEND2.
  task automatic run_tri(input logic [2:0] a_x, a_y, b_x, b_y, c_x, c_y,
                         input bit early, input bit final_drop,
                         input bit poke, input bit stray);
    int n;
    n = px_q.size();
    wait_ready();
    exp_q.push_back(ref_model());
    send_start(a_x, a_y, b_x, b_y, c_x, c_y);
    @(negedge clk);
    check("nt_send1", 64'(nt), 64'd1);
    check("xy_a", 64'({xi, yi}), 64'({a_x, a_y}));
    check("ready_busy", 64'(ready), 64'd0);
    @(negedge clk);
    check("nt_send2", 64'(nt), 64'd0);
    check("xy_b", 64'({xi, yi}), 64'({b_x, b_y}));
    if (early) busy = 1'b1;
    if (poke) begin
      start = 1'b1;
      ax = ~a_x; ay = ~a_y; bx = ~b_x; by = ~b_y; cx = ~c_x; cy = ~c_y;
    end
    @(negedge clk);
    start = 1'b0;
    check("xy_c", 64'({xi, yi}), 64'({c_x, c_y}));
    busy = !early;
    if (!early) begin
      @(negedge clk);
      po = stray;
      xo = 3'($urandom_range(0, 7));
      yo = 3'($urandom_range(0, 7));
      @(negedge clk);
      po = 1'b0;
      for (int i = 0; i < n; i++) begin
        po = 1'b1;
        xo = px_q[i];
        yo = py_q[i];
        if (final_drop && i == n - 1) busy = 1'b0;
        start = poke && (i == 0);
        @(negedge clk);
      end
      po = 1'b0;
      start = 1'b0;
      busy = 1'b0;
    end
    wait_ready();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; busy = 1'b0; po = 1'b0;
    ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0; xo = '0; yo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   64'(ready),   64'd1);
    check("rst_done",    64'(done),    64'd0);
    check("rst_nt",      64'(nt),      64'd0);
    check("rst_xy",      64'({xi, yi}), 64'd0);
    check("rst_pix_cnt", 64'(pix_cnt), 64'd0);
    check("rst_frame",   frame,        64'd0);
    check("rst_dup_err", 64'(dup_err), 64'd0);
    reset = 1'b0;

    // Half-grid triangle; start poked in SEND2 and COLLECT, stray po early.
    gen_tri(0, 0, 7, 0, 0, 7);
    run_tri(3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7, 0, 0, 1, 1);
    check("tri1_pix_cnt", 64'(pix_cnt), 64'd36);

    // Duplicate pixel and final pixel coinciding with busy falling.
    px_q = '{3'd1, 3'd2, 3'd1, 3'd3};
    py_q = '{3'd1, 3'd1, 3'd1, 3'd3};
    run_tri(3'd1, 3'd1, 3'd5, 3'd1, 3'd3, 3'd3, 0, 1, 0, 0);
    check("dup_frame",   frame,        64'h0000_0000_0800_0600);
    check("dup_pix_cnt", 64'(pix_cnt), 64'd3);
    check("dup_flag",    64'(dup_err), 64'd1);

    // Reset during COLLECT after five pixels.
    wait_ready();
    send_start(3'd0, 3'd0, 3'd6, 3'd0, 3'd0, 3'd6);
    repeat (3) @(negedge clk);
    busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      po = 1'b1;
      xo = 3'(i);
      yo = 3'd0;
      @(negedge clk);
    end
    reset = 1'b1;
    po = 1'b0;
    @(negedge clk);
    check("mrst_ready",   64'(ready),   64'd1);
    check("mrst_frame",   frame,        64'd0);
    check("mrst_pix_cnt", 64'(pix_cnt), 64'd0);
    check("mrst_nt",      64'(nt),      64'd0);
    busy = 1'b0;
    reset = 1'b0;

    // Degenerate triangle, no pixels.
    px_q.delete();
    py_q.delete();
    run_tri(3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 0, 0, 0, 0);
    check("degen_frame", frame, 64'd0);

    // busy observed only during SEND2.
    run_tri(3'd2, 3'd5, 3'd6, 3'd1, 3'd0, 3'd0, 1, 0, 0, 0);

    // Randomized triangles with random pixel streams.
    for (int t = 0; t < 30; t++) begin
      int n;
      px_q.delete();
      py_q.delete();
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++) begin
        px_q.push_back(3'($urandom_range(0, 7)));
        py_q.push_back(3'($urandom_range(0, 7)));
      end
      run_tri(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

`ifdef TRI_HOST_TIMEOUT_EN
    // busy never rises: WAIT_BUSY is entered on the edge after the c check,
    // and done must appear 15 cycles later, i.e. on the 16th negedge.
    begin
      int k = 0;
      px_q.delete();
      py_q.delete();
      wait_ready();
      exp_q.push_back(ref_model());
      send_start(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6);
      repeat (3) @(negedge clk);
      while (done !== 1'b1 && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("timeout_cycles", 64'(k), 64'd16);
      check("timeout_flag", 64'(timeout), 64'd1);
      wait_ready();
    end
`endif

    repeat (5) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tri_host.md
Name: tri_host

Overview:
- Initiator/collector on the far side of the triangle rasterizer's vertex/pixel interface.
- Accepts one triangle (three 3-bit vertices) from a control port.
- Drives the rasterizer's nt/xi/yi vertex sequence, then captures every emitted pixel (po/xo/yo) into an 8x8 bitmap.
- Reports completion, distinct pixel count and a duplicate-pixel error; serves as the stimulus/scoreboard end of the link.

Parameters:
- BUSY_WAIT_MAX, 15: cycles allowed in WAIT_BUSY before timeout. Used only with TRI_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to send a triangle; accepted only when ready=1
- ax, ay, bx, by, cx, cy  in  3 each  vertex coordinates, sampled on the accepting edge
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse when the pixel stream has ended
- pix_cnt  out  7  distinct pixels captured (0..64)
- frame  out  64  bitmap; bit index = {yo,xo}
- dup_err  out  1  sticky; a pixel was reported twice in one triangle
- timeout  out  1  sticky; present only with TRI_HOST_TIMEOUT_EN
- nt  out  1  vertex-sequence start strobe to the rasterizer
- xi, yi  out  3 each  vertex coordinates to the rasterizer
- busy  in  1  rasterizer busy
- po  in  1  pixel valid
- xo, yo  in  3 each  pixel coordinates

Behaviour:
- Reset values: state IDLE, ready=1, done=0, nt=0, xi=yi=0, pix_cnt=0, frame=0, dup_err=0, timeout=0, vertex latches=0.
- Reset mid-operation aborts immediately.
- All outputs are registered.
- States:
  - IDLE: on start, latch the six coordinates, clear frame/pix_cnt/dup_err/timeout, go to SEND1. start in any other state is ignored.
  - SEND1: nt=1, xi/yi=a. Go to SEND2.
  - SEND2: nt=0, xi/yi=b. Go to SEND3.
  - SEND3: xi/yi=c. Go to WAIT_BUSY.
  - WAIT_BUSY: xi/yi hold c. Go to COLLECT once busy has been seen high; the observation may occur during SEND2, SEND3 or WAIT_BUSY and is kept in a seen_busy flag.
  - COLLECT: every cycle with po=1, set frame[{yo,xo}].
    - If that bit was already 1, set dup_err and leave pix_cnt unchanged; otherwise pix_cnt+1.
    - When busy=0, go to DONE. po is still sampled that same cycle, because the final pixel may coincide with busy falling.
  - DONE: done=1 for one cycle, then IDLE. frame and pix_cnt hold until the next accepted start.
- Timing:
  - Vertex a appears on xi/yi the cycle after start is accepted; each vertex is held exactly one cycle, with c held until COLLECT.
  - Latency from start to nt rising: 1 cycle.
- Boundaries:
  - po=1 outside COLLECT is ignored.
  - pix_cnt saturates at 64 (cannot exceed it by construction).
  - Degenerate triangles (collinear or coincident vertices) are sent unchanged; zero pixels gives pix_cnt=0 and done still pulses.

Optional Feature:
- TRI_HOST_TIMEOUT_EN defined:
  - A 4-bit counter runs in WAIT_BUSY.
  - If busy has not been seen after BUSY_WAIT_MAX cycles, set timeout, pulse done, return to IDLE.
- Undefined: no counter, no timeout port, and WAIT_BUSY waits indefinitely.

Decomposition:
- Shared package tri_pkg:
  - COORD_W=3, GRID=8, FRAME_W=64
  - state enum for IDLE, SEND1, SEND2, SEND3, WAIT_BUSY, COLLECT, DONE
  - vertex struct {x,y}
- One sub-module, tri_frame_buf:
  - holds the 64-bit bitmap, the set-with-duplicate-detect logic and pix_cnt
  - inputs: clear, wr_en, addr[5:0]
  - outputs: frame, pix_cnt, dup
- The FSM stays in tri_host.

Test Plan:
1. start with a=(0,0), b=(7,0), c=(0,7) against the rasterizer -> nt high exactly one cycle with xi/yi=0,0; then 7,0; then 0,7. done pulses once. frame matches the lower-left half-triangle golden bitmap. pix_cnt equals its popcount. dup_err=0.
2. Behavioural model emits pixels (1,1),(2,1),(1,1) then drops busy with po=1 at (3,3) -> frame bits 9, 10, 27 set; pix_cnt=3; dup_err=1.
3. Assert reset during COLLECT after 5 pixels -> next cycle ready=1, frame=0, pix_cnt=0, nt=0.
4. start pulsed in SEND2 and COLLECT -> ignored; vertex latches unchanged; only one done.
5. Degenerate a=b=c=(3,3); model raises busy then drops it with no po -> pix_cnt=0, done pulses, frame=0.
6. TRI_HOST_TIMEOUT_EN defined, busy held 0 -> timeout=1 and done pulse exactly BUSY_WAIT_MAX=15 cycles after entering WAIT_BUSY, then ready=1.
